pipeline_stall_controller: RTL and testbench

Central stall/flush scheduler for the 5-stage pipeline. It merges the load-use hazard request, the ID-stage branch-taken flush and a multi-cycle data-memory handshake into one consistent set of per-stage write/flush/bubble controls. It sits beside the hazard detection unit and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also keeps saturating stall/flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 13 +
 rtl/sat_counter.sv | 31 +++
 rtl/pipeline_stall_controller.sv | 121 ++++++++++++
 tb/tb_pipeline_stall_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Merges load-use, branch flush and data-memory freeze into per-stage
// pipeline register controls, with saturating stall/flush counters.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_use_i,
  input  logic             branch_i,
  input  logic             mem_access_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             PCWrite_o,
  output logic             IF_ID_Stall_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Stall_o,
  output logic             ID_EX_NoOp_o,
  output logic             EX_MEM_Stall_o,
  output logic             MEM_WB_NoOp_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int              WC_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT_CYC - 1);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
  logic            freeze;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_access_i) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (mem_ack_i) begin
          state_d = S_DONE;
        end else if (wait_cnt_q == WC_LAST) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      // mem_access_i here still describes the instruction just completed.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign freeze = ((state_q == S_IDLE) && mem_access_i) || (state_q == S_WAIT);

  always_comb begin
    mem_req_o      = 1'b0;
    PCWrite_o      = 1'b1;
    IF_ID_Stall_o  = 1'b0;
    IF_ID_Flush_o  = 1'b0;
    ID_EX_Stall_o  = 1'b0;
    ID_EX_NoOp_o   = 1'b0;
    EX_MEM_Stall_o = 1'b0;
    MEM_WB_NoOp_o  = 1'b0;
    if (rst_i) begin
      mem_req_o = (state_q == S_WAIT);
      if (freeze) begin
        PCWrite_o      = 1'b0;
        IF_ID_Stall_o  = 1'b1;
        ID_EX_Stall_o  = 1'b1;
        EX_MEM_Stall_o = 1'b1;
        MEM_WB_NoOp_o  = 1'b1;
      end else if (load_use_i) begin
        // Branch operands are not ready yet, so the branch waits too.
        PCWrite_o     = 1'b0;
        IF_ID_Stall_o = 1'b1;
        ID_EX_NoOp_o  = 1'b1;
      end else if (branch_i) begin
        IF_ID_Flush_o = 1'b1;
      end
    end
  end

  assign timeout_o = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (~PCWrite_o),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (IF_ID_Flush_o),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with a short timeout and
// 3-bit counters so timeout and saturation are reachable quickly.
module tb_pipeline_stall_controller;

  localparam int TIMEOUT_CYC = 4;
  localparam int CNT_W       = 3;

  // {mem_req, PCWrite, IF_ID_Stall, IF_ID_Flush, ID_EX_Stall, ID_EX_NoOp, EX_MEM_Stall, MEM_WB_NoOp}
  localparam logic [7:0] C_IDLE = 8'b0100_0000;
  localparam logic [7:0] C_FRZI = 8'b0010_1011;
  localparam logic [7:0] C_FRZW = 8'b1010_1011;
  localparam logic [7:0] C_LU   = 8'b0010_0100;
  localparam logic [7:0] C_BR   = 8'b0101_0000;

  logic             clk = 1'b0;
  logic             rst_i, load_use_i, branch_i, mem_access_i, mem_ack_i;
  logic             mem_req_o, PCWrite_o, IF_ID_Stall_o, IF_ID_Flush_o;
  logic             ID_EX_Stall_o, ID_EX_NoOp_o, EX_MEM_Stall_o, MEM_WB_NoOp_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [7:0]       ctrl;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .load_use_i     (load_use_i),
    .branch_i       (branch_i),
    .mem_access_i   (mem_access_i),
    .mem_ack_i      (mem_ack_i),
    .mem_req_o      (mem_req_o),
    .PCWrite_o      (PCWrite_o),
    .IF_ID_Stall_o  (IF_ID_Stall_o),
    .IF_ID_Flush_o  (IF_ID_Flush_o),
    .ID_EX_Stall_o  (ID_EX_Stall_o),
    .ID_EX_NoOp_o   (ID_EX_NoOp_o),
    .EX_MEM_Stall_o (EX_MEM_Stall_o),
    .MEM_WB_NoOp_o  (MEM_WB_NoOp_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
  );

  assign ctrl = {mem_req_o, PCWrite_o, IF_ID_Stall_o, IF_ID_Flush_o,
                 ID_EX_Stall_o, ID_EX_NoOp_o, EX_MEM_Stall_o, MEM_WB_NoOp_o};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    $display("check %-14s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic lu, input logic br,
                       input logic ma, input logic ack);
    rst_i = r; load_use_i = lu; branch_i = br; mem_access_i = ma; mem_ack_i = ack;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    // Reset with every input high
    drive(0, 1, 1, 1, 1);
    sample(); chk("rst_ctrl0", ctrl, C_IDLE);
    chk("rst_stall", 8'(stall_cnt_o), 8'd0);
    chk("rst_flush", 8'(flush_cnt_o), 8'd0);
    chk("rst_tmo", 8'(timeout_o), 8'd0);
    tick(); sample(); chk("rst_ctrl1", ctrl, C_IDLE);
    tick(); drive(1, 0, 0, 0, 0);
    sample(); chk("idle", ctrl, C_IDLE);

    // Load-use beats branch, then branch alone flushes
    tick(); drive(1, 1, 1, 0, 0);
    sample(); chk("lu_br", ctrl, C_LU);
    tick(); drive(1, 0, 1, 0, 0);
    sample(); chk("br", ctrl, C_BR);
    tick(); drive(1, 0, 0, 0, 0);
    sample(); chk("after_br", ctrl, C_IDLE);
    chk("lu_stall_cnt", 8'(stall_cnt_o), 8'd1);
    chk("br_flush_cnt", 8'(flush_cnt_o), 8'd1);

    // Clear counters
    tick(); drive(0, 0, 0, 0, 0);
    tick(); drive(1, 0, 0, 0, 0);
    sample(); chk("clr_stall", 8'(stall_cnt_o), 8'd0);

    // Memory access, ack in the 3rd WAIT cycle
    tick(); drive(1, 0, 0, 1, 0);
    sample(); chk("m_idle_frz", ctrl, C_FRZI);
    tick(); sample(); chk("m_wait1", ctrl, C_FRZW);
    tick(); drive(1, 1, 1, 1, 0);
    sample(); chk("m_wait2_ign", ctrl, C_FRZW);
    tick(); drive(1, 0, 0, 1, 1);
    sample(); chk("m_wait3_ack", ctrl, C_FRZW);
    tick(); drive(1, 0, 0, 1, 0);
    sample(); chk("m_done", ctrl, C_IDLE);
    chk("m_stall_cnt", 8'(stall_cnt_o), 8'd4);
    chk("m_no_tmo", 8'(timeout_o), 8'd0);

    // Back-to-back access right after DONE, ack in first WAIT cycle
    tick(); drive(1, 0, 0, 1, 0);
    sample(); chk("b2b_idle", ctrl, C_FRZI);
    tick(); drive(1, 0, 0, 1, 1);
    sample(); chk("b2b_wait", ctrl, C_FRZW);
    tick(); drive(1, 0, 0, 0, 0);
    sample(); chk("b2b_done", ctrl, C_IDLE);
    chk("b2b_stall_cnt", 8'(stall_cnt_o), 8'd6);

    // Timeout: no ack for 4 WAIT cycles
    tick(); drive(1, 0, 0, 1, 0);
    sample(); chk("t_idle", ctrl, C_FRZI);
    for (int i = 0; i < TIMEOUT_CYC; i++) begin
      tick(); sample(); chk($sformatf("t_wait%0d", i + 1), ctrl, C_FRZW);
    end
    chk("t_tmo_pre", 8'(timeout_o), 8'd0);
    tick(); sample(); chk("t_done", ctrl, C_IDLE);
    chk("t_tmo_set", 8'(timeout_o), 8'd1);
    tick(); drive(1, 0, 0, 0, 1);
    sample(); chk("t_ack_idle", ctrl, C_IDLE);
    tick(); drive(1, 0, 0, 0, 0);
    sample(); chk("t_still_idle", ctrl, C_IDLE);
    chk("t_tmo_sticky", 8'(timeout_o), 8'd1);
    chk("t_stall_sat", 8'(stall_cnt_o), 8'd7);

    // Reset clears timeout and counters
    tick(); drive(0, 0, 0, 0, 0);
    tick(); drive(1, 0, 0, 0, 0);
    sample(); chk("r_tmo_clr", 8'(timeout_o), 8'd0);
    chk("r_stall_clr", 8'(stall_cnt_o), 8'd0);

    // Reset in the 2nd WAIT cycle abandons the access
    tick(); drive(1, 0, 0, 1, 0);
    sample(); chk("rw_idle", ctrl, C_FRZI);
    tick(); sample(); chk("rw_wait1", ctrl, C_FRZW);
    tick(); drive(0, 0, 0, 1, 0);
    sample(); chk("rw_rst", ctrl, C_IDLE);
    tick(); drive(1, 0, 0, 1, 0);
    sample(); chk("rw_back_idle", ctrl, C_FRZI);
    tick(); drive(1, 0, 0, 1, 1);
    sample(); chk("rw_wait", ctrl, C_FRZW);
    tick(); drive(1, 0, 0, 0, 0);
    sample(); chk("rw_done", ctrl, C_IDLE);
    chk("rw_stall_cnt", 8'(stall_cnt_o), 8'd2);

    // Saturation: 10 load-use stalls, 9 branch flushes
    for (int i = 0; i < 10; i++) begin
      tick(); drive(1, 1, 0, 0, 0);
    end
    tick(); drive(1, 0, 0, 0, 0);
    sample(); chk("sat_stall", 8'(stall_cnt_o), 8'd7);
    for (int i = 0; i < 9; i++) begin
      tick(); drive(1, 0, 1, 0, 0);
    end
    tick(); drive(1, 0, 0, 0, 0);
    sample(); chk("sat_flush", 8'(flush_cnt_o), 8'd7);
    chk("sat_idle", ctrl, C_IDLE);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
